// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the two requester ports (CPU and dump/debug), the RAM-side port and
// the busy flag of the RAM arbiter into one interface.
//
// Parameters:
//   ADDR_W : RAM address width
//   DATA_W : RAM data width
//
// Signals (per requester, prefix cpu_ / dbg_):
//   *_req, *_we, *_addr, *_din   : request, write enable, address, write data
//   *_gnt                        : one-cycle grant pulse
//   *_rvalid                     : one-cycle read-data-valid pulse
//   *_dout                       : registered read data
// RAM side:
//   ram_we, ram_addr, ram_din    : write enable, address, write data to RAM
//   ram_dout                     : synchronous RAM read data (1-cycle latency)
// Status:
//   busy                         : arbiter is not idle
//
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters plus RAM)
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_dout;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_din;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_dout;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_gnt, cpu_rvalid, cpu_dout,
    input  dbg_req, dbg_we, dbg_addr, dbg_din,
    output dbg_gnt, dbg_rvalid, dbg_dout,
    output ram_we, ram_addr, ram_din,
    input  ram_dout,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_gnt, cpu_rvalid, cpu_dout,
    output dbg_req, dbg_we, dbg_addr, dbg_din,
    input  dbg_gnt, dbg_rvalid, dbg_dout,
    input  ram_we, ram_addr, ram_din,
    output ram_dout,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port synchronous RAM between a CPU requester and a
// dump/debug requester. Every access takes a fixed three cycles:
//   IDLE   : sample requests, pick a winner, latch its we/addr/din
//   ACCESS : drive the RAM from the latched fields, pulse the winner's gnt
//   RESP   : RAM read data is valid; for reads, register it into the
//            winner's dout and pulse its rvalid in the following cycle
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : asynchronous, active-high reset
//   bus    : ram_arbiter_if.slave (requester, RAM and busy signals)
//
// Configuration macro:
//   RAM_ARB_ROUND_ROBIN_EN
//     defined   : on contention the requester that did not win the previous
//                 access wins (CPU wins the first contention after reset)
//     undefined : fixed priority, CPU always wins on contention
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;

  // Fields of the winning request, captured in IDLE and used for the access.
  logic              r_latWe;
  logic              r_latDbg;
  logic [ADDR_W-1:0] r_latAddr;
  logic [DATA_W-1:0] r_latDin;

  logic              r_ramWe;
  logic              r_cpuGnt;
  logic              r_dbgGnt;
  logic              r_cpuRvalid;
  logic              r_dbgRvalid;
  logic [DATA_W-1:0] r_cpuDout;
  logic [DATA_W-1:0] r_dbgDout;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic              r_lastDbg;
`endif

  logic              w_anyReq;
  logic              w_dbgWins;
  logic              w_selWe;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selDin;

  // Winner selection. A lone requester always wins; only contention depends
  // on the arbitration mode.
  assign w_anyReq  = bus.cpu_req | bus.dbg_req;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign w_dbgWins = bus.dbg_req & (~bus.cpu_req | ~r_lastDbg);
`else
  assign w_dbgWins = bus.dbg_req & ~bus.cpu_req;
`endif

  assign w_selWe   = w_dbgWins ? bus.dbg_we   : bus.cpu_we;
  assign w_selAddr = w_dbgWins ? bus.dbg_addr : bus.cpu_addr;
  assign w_selDin  = w_dbgWins ? bus.dbg_din  : bus.cpu_din;

  // Access sequencer. All outputs are registered: gnt and ram_we are set on
  // the edge that enters ACCESS so they are high for exactly the ACCESS
  // cycle, and rvalid is set on the edge leaving RESP so it is high for the
  // IDLE cycle that follows. Pulses default to 0 every cycle, so a reset
  // mid-access leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_latWe     <= 1'b0;
      r_latDbg    <= 1'b0;
      r_latAddr   <= '0;
      r_latDin    <= '0;
      r_ramWe     <= 1'b0;
      r_cpuGnt    <= 1'b0;
      r_dbgGnt    <= 1'b0;
      r_cpuRvalid <= 1'b0;
      r_dbgRvalid <= 1'b0;
      r_cpuDout   <= '0;
      r_dbgDout   <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      r_lastDbg   <= 1'b1;
`endif
    end else begin
      r_ramWe     <= 1'b0;
      r_cpuGnt    <= 1'b0;
      r_dbgGnt    <= 1'b0;
      r_cpuRvalid <= 1'b0;
      r_dbgRvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_latDbg  <= w_dbgWins;
            r_latWe   <= w_selWe;
            r_latAddr <= w_selAddr;
            r_latDin  <= w_selDin;
            r_ramWe   <= w_selWe;
            r_cpuGnt  <= ~w_dbgWins;
            r_dbgGnt  <= w_dbgWins;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            r_lastDbg <= w_dbgWins;
`endif
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_state <= RESP;
        end
        RESP: begin
          // RAM read data for the address driven in ACCESS is valid now.
          if (!r_latWe) begin
            if (r_latDbg) begin
              r_dbgDout   <= bus.ram_dout;
              r_dbgRvalid <= 1'b1;
            end else begin
              r_cpuDout   <= bus.ram_dout;
              r_cpuRvalid <= 1'b1;
            end
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ram_addr/ram_din follow the latched fields, which only change on entry
  // to ACCESS, so they hold their last driven value in the other states.
  assign bus.ram_we     = r_ramWe;
  assign bus.ram_addr   = r_latAddr;
  assign bus.ram_din    = r_latDin;
  assign bus.cpu_gnt    = r_cpuGnt;
  assign bus.dbg_gnt    = r_dbgGnt;
  assign bus.cpu_rvalid = r_cpuRvalid;
  assign bus.dbg_rvalid = r_dbgRvalid;
  assign bus.cpu_dout   = r_cpuDout;
  assign bus.dbg_dout   = r_dbgDout;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the RAM address width (256 words).
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the RAM data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have CPU requester inputs: cpu_req (1), cpu_we (1), cpu_addr (ADDR_W) and cpu_din (DATA_W), meaning request, write-enable, address and write data.
REQ-006 The block SHALL have CPU requester outputs: cpu_gnt (1, one-cycle grant pulse), cpu_rvalid (1, one-cycle read-data-valid pulse) and cpu_dout (DATA_W, registered read data).
REQ-007 The block SHALL have dump/debug requester ports dbg_req, dbg_we, dbg_addr, dbg_din, dbg_gnt, dbg_rvalid and dbg_dout, with the same widths and meanings as the CPU ports.
REQ-008 The block SHALL have RAM-side ports: ram_we (output, 1), ram_addr (output, ADDR_W), ram_din (output, DATA_W, write data to RAM) and ram_dout (input, DATA_W, synchronous RAM read data valid one cycle after the address is applied).
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 The FSM SHALL have three states, IDLE, ACCESS and RESP, with a fixed 3-cycle access: IDLE -> ACCESS -> RESP -> IDLE.
REQ-011 In IDLE with no request asserted, the FSM SHALL remain in IDLE.
REQ-012 In IDLE with any request asserted, the FSM SHALL select one winner, latch its we, addr and din into internal registers, record the winner's identity, and move to ACCESS.
REQ-013 In ACCESS, ram_addr and ram_din SHALL be driven from the latched registers, ram_we SHALL equal the latched we, the winner's gnt SHALL pulse high for exactly this cycle, and the FSM SHALL move to RESP.
REQ-014 In RESP, for a read, the winner's dout SHALL register ram_dout and the winner's rvalid SHALL pulse high on the following cycle (IDLE); for a write, no rvalid SHALL be issued and dout SHALL be unchanged.
REQ-015 Read latency, measured from req sampled in IDLE to rvalid high, SHALL be 3 cycles; the non-winner's dout SHALL hold its value.
REQ-016 ram_we SHALL be 0 in every state other than ACCESS; ram_addr and ram_din SHALL hold their last driven values outside ACCESS.
REQ-017 A requester SHALL hold req, we, addr and din stable until its gnt; the block samples them only in IDLE, so changes made after winning have no effect.
REQ-018 A requester that keeps req high after its gnt SHALL be treated as a new request at the next IDLE.
REQ-019 At most one gnt and at most one rvalid SHALL be high in any cycle; the two gnts SHALL never both be high.
REQ-020 With a single requester active, that requester SHALL win regardless of arbitration mode.
REQ-021 Simultaneous requests SHALL be resolved per the Configuration section.

Reset
REQ-022 Asserting reset SHALL immediately force the FSM to IDLE and clear ram_we, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid and busy to 0.
REQ-023 Reset SHALL clear ram_addr, ram_din, cpu_dout, dbg_dout and the latched registers to 0, and set the last-winner register to DBG.
REQ-024 A reset asserted mid-access SHALL abandon the access with no later gnt, rvalid or ram_we pulse for it; the first post-reset request SHALL be arbitrated fresh.

Configuration
REQ-025 With macro RAM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester that did not win the previous access (last-winner register), so CPU wins the first contention after reset.
REQ-026 Without RAM_ARB_ROUND_ROBIN_EN defined, the CPU SHALL always win simultaneous requests (fixed priority), and the last-winner register SHALL be absent or unused.

Verification
REQ-027 Reset -> all outputs 0, busy=0; then CPU write addr 0x05 data 0xBEEF -> cpu_gnt and ram_we high in the same cycle, with ram_addr=0x05 and ram_din=0xBEEF.
REQ-028 CPU read addr 0x05 after that write -> cpu_rvalid high 3 cycles after req with cpu_dout=0xBEEF, and no dbg_rvalid.
REQ-029 cpu_req and dbg_req held high together for 4 accesses -> with the macro, grants go CPU, DBG, CPU, DBG; without the macro, grants go CPU four times while DBG waits.
REQ-030 dbg read addr 0xFF containing 0x1234 -> dbg_dout=0x1234 with dbg_rvalid pulsed, and cpu_dout unchanged.
REQ-031 Reset asserted while a write is in ACCESS -> ram_we drops immediately, the FSM is in IDLE, and no rvalid or gnt follows.
REQ-032 dbg_addr changed after dbg_gnt while req held -> the current access uses the old address, and the next access uses the new address.
